adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares the single 16-bit ripple adder (`full_adder_16bit`) between two requesters and sequences 32-bit add/subtract operations through it in two half-word passes. The block performs arbitration, operand capture, low/high pass sequencing with carry hand-off, and a held response with valid/ready backpressure. It sits between the two requesting units and the shared adder datapath.

## Interface
Parameters:
- `FAIR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority where req0 always wins.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b` in 32: operands.
- `req0_sub` in 1: 1 computes a−b, 0 computes a+b.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as requester 0.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_sum` out 32: result.
- `rsp_cout` out 1: carry out of bit 31; for subtract, 1 means no borrow.
- `rsp_id` out 1: requester that issued the result.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → LO → HI → RESP → IDLE.
- **IDLE:**
  - If either `reqN_valid` is high, grant one requester and drive its `reqN_ready`.
  - `reqN_ready` is combinational and is high only in IDLE, only for the granted requester.
  - On that edge, capture a, b, sub and id, then go to LO. If neither valid is high, stay in IDLE.
- **Arbitration:**
  - `FAIR`=1: `last_grant` register; when both requesters are valid, grant `!last_grant`; when one is valid, grant it.
  - `last_grant` updates on acceptance. Reset value 1, so req0 wins the first tie.
  - `FAIR`=0: req0 wins every tie.
- **Operand preparation:** `b_eff` = sub ? ~b : b.
- **LO:** adder inputs are a[15:0], b_eff[15:0], cin = sub. Register sum[15:0] and the carry. Go to HI.
- **HI:** adder inputs are a[31:16], b_eff[31:16], cin = registered LO carry. Register sum[31:16] and cout. Go to RESP.
- **RESP:**
  - `rsp_valid` is high; `rsp_sum`, `rsp_cout` and `rsp_id` are held stable until `rsp_ready` is sampled high.
  - On that edge go to IDLE. The next acceptance occurs at the earliest on the following cycle.
- **Arithmetic:** modulo 2^32; no overflow flag. `rsp_cout` is the true carry out of bit 31.
- **Requester rules:**
  - A requester may drop `valid` before it sees `ready`; nothing is captured.
  - Operand inputs are sampled only on the acceptance edge.
- **Reset:**
  - Asynchronous assertion in any state forces IDLE.
  - Any in-flight operation is discarded; no response is produced for it.

## Timing
- Accept at edge T (IDLE, valid & ready). LO runs in cycle T+1, HI in T+2, and `rsp_valid` is high from T+3.
- Latency from acceptance to `rsp_valid` is 3 cycles. Minimum issue interval is 4 cycles with `rsp_ready` held high.
- The adder is combinational inside a single cycle; the critical path is the 16-bit ripple plus the operand mux.
- Reset values:
  - Outputs: `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `busy`=0, `req0_ready`=0, `req1_ready`=0.
  - Internal: state=IDLE, `last_grant`=1.
- Simultaneous events:
  - Both requesters valid in IDLE: one grant per the arbitration rule; the loser's ready stays 0 and it waits.
  - `rsp_ready` high while not in RESP is ignored.

## Structure
- Package `adder_arb_pkg` holds:
  - the state enum (IDLE, LO, HI, RESP);
  - `HALF_W`=16 and `WORD_W`=32;
  - the requester-id type.
- Exactly one instance of `full_adder_16bit`, time-shared between the LO and HI passes. No other sub-modules.
- Registers:
  - captured operands (a, b_eff, sub, id);
  - LO carry;
  - result low and high halves, and cout;
  - `last_grant`.

## Test plan
- req0 add, a=0x0000_FFFF, b=0x0000_0001 → `rsp_sum`=0x0001_0000, `rsp_cout`=0, `rsp_id`=0; `rsp_valid` rises 3 cycles after acceptance. This checks the LO→HI carry.
- Overflow: a=0xFFFF_FFFF, b=0x0000_0001 → `rsp_sum`=0x0000_0000, `rsp_cout`=1.
- Subtract via req1:
  - a=5, b=7 → 0xFFFF_FFFE, cout=0, id=1;
  - a=7, b=5 → 0x0000_0002, cout=1.
- Both requesters valid continuously with `rsp_ready`=1:
  - `FAIR`=1 → grants 0,1,0,1, one acceptance every 4 cycles;
  - `FAIR`=0 → grants 0,0,0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and all result fields stay stable, and both readys stay 0; release → IDLE on the next edge.
- Assert `rst_n` low during HI → all outputs go to reset values immediately with no response for that operation; after release, a new req0 add of 3+4 → 7 with normal latency.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and widths for the two-pass adder arbiter
package adder_arb_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    typedef logic req_id_t;

    // Subtract is a + ~b + 1; the +1 arrives as the low-pass carry-in.
    function automatic logic [WORD_W-1:0] eff_operand(input logic [WORD_W-1:0] b, input logic sub);
        return sub ? ~b : b;
    endfunction

endpackage

// File: rtl/full_adder_16bit.sv
// rtl/full_adder_16bit.sv - 16-bit ripple-carry adder shared by the low and high passes
module full_adder_16bit
    import adder_arb_pkg::*;
(
    input  logic [HALF_W-1:0] i_a,
    input  logic [HALF_W-1:0] i_b,
    input  logic              i_cin,
    output logic [HALF_W-1:0] o_sum,
    output logic              o_cout
);

    logic w_carry;

    always_comb begin
        w_carry = i_cin;
        o_sum   = '0;
        for (int i = 0; i < HALF_W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - arbitrates two requesters onto one 16-bit adder, 32-bit ops in two passes
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_sum,
    output logic              rsp_cout,
    output req_id_t           rsp_id,
    output logic              busy
);

    state_t            r_state;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b_eff;
    logic              r_sub;
    req_id_t           r_id;
    logic              r_lo_carry;
    logic [HALF_W-1:0] r_sum_lo;
    logic [HALF_W-1:0] r_sum_hi;
    logic              r_cout;
    req_id_t           r_last_grant;
    logic              r_rsp_valid;

    req_id_t           w_grant;
    logic              w_any;
    logic              w_idle;
    logic [WORD_W-1:0] w_sel_a;
    logic [WORD_W-1:0] w_sel_b;
    logic              w_sel_sub;
    logic [HALF_W-1:0] w_add_a;
    logic [HALF_W-1:0] w_add_b;
    logic              w_add_cin;
    logic [HALF_W-1:0] w_add_sum;
    logic              w_add_cout;

    assign w_any  = req0_valid | req1_valid;
    assign w_idle = (r_state == IDLE);

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant = FAIR ? ~r_last_grant : 1'b0;
        end else begin
            w_grant = ~req0_valid;
        end
    end

    assign req0_ready = w_idle & req0_valid & ~w_grant;
    assign req1_ready = w_idle & req1_valid & w_grant;

    assign w_sel_a   = w_grant ? req1_a   : req0_a;
    assign w_sel_b   = w_grant ? req1_b   : req0_b;
    assign w_sel_sub = w_grant ? req1_sub : req0_sub;

    // The single adder sees the low halves in LO and the high halves in HI.
    assign w_add_a   = (r_state == HI) ? r_a[WORD_W-1:HALF_W]     : r_a[HALF_W-1:0];
    assign w_add_b   = (r_state == HI) ? r_b_eff[WORD_W-1:HALF_W] : r_b_eff[HALF_W-1:0];
    assign w_add_cin = (r_state == HI) ? r_lo_carry               : r_sub;

    full_adder_16bit u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b_eff      <= '0;
            r_sub        <= 1'b0;
            r_id         <= 1'b0;
            r_lo_carry   <= 1'b0;
            r_sum_lo     <= '0;
            r_sum_hi     <= '0;
            r_cout       <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a          <= w_sel_a;
                        r_b_eff      <= eff_operand(w_sel_b, w_sel_sub);
                        r_sub        <= w_sel_sub;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= LO;
                    end
                end
                LO: begin
                    r_sum_lo   <= w_add_sum;
                    r_lo_carry <= w_add_cout;
                    r_state    <= HI;
                end
                HI: begin
                    r_sum_hi    <= w_add_sum;
                    r_cout      <= w_add_cout;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = {r_sum_hi, r_sum_lo};
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;
    assign busy      = ~w_idle;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed scoreboard bench for adder_arbiter (round-robin and fixed priority)
module tb_adder_arbiter;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_sub, req1_sub;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_ready;

    logic        req0_ready, req1_ready, rsp_valid, rsp_cout, rsp_id, busy;
    logic [31:0] rsp_sum;
    logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_cout, f_rsp_id, f_busy;
    logic [31:0] f_rsp_sum;

    exp_t q[$];
    exp_t qf[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.FAIR(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .busy(busy)
    );

    adder_arbiter #(.FAIR(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(f_rsp_sum), .rsp_cout(f_rsp_cout),
        .rsp_id(f_rsp_id), .busy(f_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t e;
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
        end else begin
            {e.cout, e.sum} = {1'b0, a} + {1'b0, b};
        end
        e.id = id;
        return e;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_sum"}, rsp_sum, 0);
        chk({tag, "_rsp_cout"}, rsp_cout, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
    endtask

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", id ? req1_ready : req0_ready, 1);
        q.push_back(model(id, a, b, sub));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (rsp_valid || lat >= 20) break;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic take_rsp(input string tag);
        exp_t e;
        rsp_ready = 1'b1;
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_sum"}, rsp_sum, e.sum);
            chk({tag, "_cout"}, rsp_cout, e.cout);
            chk({tag, "_id"}, rsp_id, e.id);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic recv(input string tag);
        int lat;
        wait_rsp(lat);
        chk({tag, "_latency"}, lat, 3);
        take_rsp(tag);
    endtask

    initial begin
        exp_t e;
        exp_t ef;
        int   lat, cyc, last, nres, nresf;

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_sub = 1'b0; req1_sub = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        recv("lo_hi_carry");
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        recv("overflow");
        send(1'b1, 32'd5, 32'd7, 1'b1);
        recv("sub_borrow");
        send(1'b1, 32'd7, 32'd5, 1'b1);
        recv("sub_noborrow");

        // Backpressure: response must hold for 5 cycles while both requesters wait.
        send(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_rsp(lat);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        e = q[0];
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_sum", rsp_sum, e.sum);
            chk("bp_cout", rsp_cout, e.cout);
            chk("bp_id", rsp_id, e.id);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            @(negedge clk);
        end
        take_rsp("bp");
        @(negedge clk);
        chk("bp_idle_valid", rsp_valid, 0);
        chk("bp_idle_busy", busy, 0);
        chk("bp_rr_grant1", req1_ready, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted during the high pass discards the operation.
        send(1'b0, 32'hAAAA_0000, 32'h5555_FFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("hi_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", rsp_valid, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send(1'b0, 32'd3, 32'd4, 1'b0);
        recv("post_reset");

        // Contention: both requesters always valid, consumer always ready.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        qf.delete();
        req0_a = 32'h1000_0000; req0_b = 32'h0000_0234; req0_sub = 1'b0;
        req1_a = 32'h0000_0010; req1_b = 32'h0000_0020; req1_sub = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q.push_back(i[0] ? model(1'b1, req1_a, req1_b, 1'b1) : model(1'b0, req0_a, req0_b, 1'b0));
            qf.push_back(model(1'b0, req0_a, req0_b, 1'b0));
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cyc = 0; last = 0; nres = 0; nresf = 0;
        while (nres < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("one_grant", req0_ready & req1_ready, 0);
            if (rsp_valid) begin
                e = q.pop_front();
                chk("rr_id", rsp_id, e.id);
                chk("rr_sum", rsp_sum, e.sum);
                chk("rr_cout", rsp_cout, e.cout);
                if (nres > 0) chk("rr_interval", cyc - last, 4);
                last = cyc;
                nres++;
            end
            if (f_rsp_valid) begin
                if (qf.size() == 0) begin
                    chk("fix_extra", 1, 0);
                end else begin
                    ef = qf.pop_front();
                    chk("fix_id", f_rsp_id, ef.id);
                    chk("fix_sum", f_rsp_sum, ef.sum);
                end
                nresf++;
            end
        end
        chk("rr_count", nres, 4);
        chk("fix_count", nresf, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
